// File: rtl/keypad_matrix_scanner.sv
// Debounced matrix-keypad scanner with a press/release event FIFO (valid/ready).
// Optional KEYPAD_GHOST_REJECT_EN: frames showing a ghost pattern are treated as unstable.
module keypad_matrix_scanner #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned SCAN_DIV  = 100,
    parameter int unsigned DEBOUNCE  = 4,
    parameter int unsigned EVT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ROWS-1:0]              row_n,
    output logic [COLS-1:0]              col_n,
    output logic [ROWS*COLS-1:0]         key_map,
    output logic                         frame_tick,
    output logic                         evt_valid,
    output logic [$clog2(ROWS*COLS)-1:0] evt_code,
    output logic                         evt_press,
    input  logic                         evt_ready
);
    localparam int unsigned NKEY = ROWS * COLS;
    localparam int unsigned CW   = $clog2(NKEY);
    localparam int unsigned DW   = $clog2(SCAN_DIV);
    localparam int unsigned XW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned AW   = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
    localparam int unsigned NW   = $clog2(EVT_DEPTH + 1);
    localparam int unsigned SW   = 4;
    localparam int unsigned EW   = CW + 1;

    logic            run;
    logic [DW-1:0]   div;
    logic [XW-1:0]   col_idx;
    logic [NKEY-1:0] raw_acc;
    logic [NKEY-1:0] prev_raw;
    logic [NKEY-1:0] diff;
    logic [SW-1:0]   stab_cnt;
    logic            push_vld;
    logic [EW-1:0]   push_data;
    logic [EW-1:0]   mem [EVT_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [NW-1:0]   count;

    logic            div_tc;
    logic            frame_end;
    logic [XW-1:0]   col_nxt;
    logic [NKEY-1:0] raw_new;
    logic            ghost;
    logic [SW-1:0]   stab_nxt;
    logic            commit;
    logic            space;
    logic            emit;
    logic [CW-1:0]   emit_idx;
    logic [NKEY-1:0] diff_nxt;
    logic            pop;
    logic [NW-1:0]   count_nxt;
    logic [AW-1:0]   rd_inc;
    logic [AW-1:0]   wr_inc;
    logic [EW-1:0]   head_nxt;

    // Column stepping, raw frame assembly and debounce decision
    always_comb begin
        div_tc    = run && (div == DW'(SCAN_DIV - 1));
        frame_end = div_tc && (col_idx == XW'(COLS - 1));
        col_nxt   = col_idx;
        if (div_tc) begin
            col_nxt = frame_end ? '0 : col_idx + XW'(1);
        end
        raw_new = raw_acc;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (XW'(c) == col_idx) begin
                    raw_new[c*ROWS+r] = ~row_n[r];
                end
            end
        end
        if (ghost) begin
            stab_nxt = '0;
        end else if (raw_new == prev_raw) begin
            stab_nxt = (stab_cnt >= SW'(DEBOUNCE)) ? SW'(DEBOUNCE) : stab_cnt + SW'(1);
        end else begin
            stab_nxt = SW'(1);
        end
        commit = frame_end && !ghost && (stab_nxt >= SW'(DEBOUNCE)) &&
                 (raw_new != key_map) && (diff == '0);
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    logic [COLS-1:0] row_bits [ROWS];
    logic [ROWS-1:0] row_multi;
    logic [COLS-1:0] col_multi;

    // Ghost: a closed key whose row and column each hold another closed key
    always_comb begin
        ghost     = 1'b0;
        row_bits  = '{default: '0};
        row_multi = '0;
        col_multi = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                row_bits[r][c] = raw_new[c*ROWS+r];
            end
            row_multi[r] = ($countones(row_bits[r]) > 1);
        end
        for (int c = 0; c < COLS; c++) begin
            col_multi[c] = ($countones(raw_new[c*ROWS +: ROWS]) > 1);
        end
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                ghost = ghost | (raw_new[c*ROWS+r] & row_multi[r] & col_multi[c]);
            end
        end
    end
`else
    assign ghost = 1'b0;
`endif

    // Emitter: lowest pending diff bit goes out when the FIFO (plus in-flight push) has room
    always_comb begin
        space    = ({1'b0, count} + (NW+1)'(push_vld)) < (NW+1)'(EVT_DEPTH);
        emit     = (diff != '0) && space;
        emit_idx = '0;
        for (int i = 0; i < NKEY; i++) begin
            if (diff[NKEY-1-i]) begin
                emit_idx = CW'(NKEY - 1 - i);
            end
        end
        diff_nxt = diff;
        if (commit) begin
            diff_nxt = raw_new ^ key_map;
        end else if (emit) begin
            diff_nxt[emit_idx] = 1'b0;
        end
    end

    // FWFT FIFO next state; the head is kept in the output registers
    always_comb begin
        pop       = evt_valid && evt_ready;
        count_nxt = count + NW'(push_vld) - NW'(pop);
        rd_inc    = (rd_ptr == AW'(EVT_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
        wr_inc    = (wr_ptr == AW'(EVT_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
        head_nxt  = {evt_code, evt_press};
        if (pop) begin
            if (count > NW'(1)) begin
                head_nxt = mem[rd_inc];
            end else if (push_vld) begin
                head_nxt = push_data;
            end
        end else if ((count == '0) && push_vld) begin
            head_nxt = push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            div        <= '0;
            col_idx    <= '0;
            col_n      <= '1;
            raw_acc    <= '0;
            prev_raw   <= '0;
            stab_cnt   <= '0;
            frame_tick <= 1'b0;
            key_map    <= '0;
            diff       <= '0;
            push_vld   <= 1'b0;
            push_data  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            evt_valid  <= 1'b0;
            evt_code   <= '0;
            evt_press  <= 1'b0;
            for (int i = 0; i < EVT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            run <= 1'b1;
            if (run) begin
                div <= div_tc ? '0 : div + DW'(1);
            end
            col_idx <= col_nxt;
            col_n   <= ~(COLS'(1) << col_nxt);
            if (div_tc) begin
                raw_acc <= raw_new;
            end
            frame_tick <= frame_end;
            if (frame_end) begin
                stab_cnt <= stab_nxt;
                if (!ghost) begin
                    prev_raw <= raw_new;
                end
            end
            if (commit) begin
                key_map <= raw_new;
            end
            diff     <= diff_nxt;
            push_vld <= emit;
            if (emit) begin
                push_data <= {emit_idx, key_map[emit_idx]};
            end
            if (push_vld) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_inc;
            end
            if (pop) begin
                rd_ptr <= rd_inc;
            end
            count                 <= count_nxt;
            evt_valid             <= (count_nxt != '0);
            {evt_code, evt_press} <= head_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural 4x4 keypad on the pins.
module tb_keypad_matrix_scanner;
    localparam int unsigned ROWS      = 4;
    localparam int unsigned COLS      = 4;
    localparam int unsigned SCAN_DIV  = 20;
    localparam int unsigned DEBOUNCE  = 3;
    localparam int unsigned EVT_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] key_map;
    logic        frame_tick;
    logic        evt_valid;
    logic [3:0]  evt_code;
    logic        evt_press;
    logic        evt_ready = 1'b1;
    logic [15:0] keys = '0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          t1;
    logic [4:0]  evq [$];

    keypad_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE), .EVT_DEPTH(EVT_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
        .key_map(key_map), .frame_tick(frame_tick), .evt_valid(evt_valid),
        .evt_code(evt_code), .evt_press(evt_press), .evt_ready(evt_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer log of accepted events as {code, press}
    always @(posedge clk) begin
        if (rst_n && evt_valid && evt_ready) evq.push_back({evt_code, evt_press});
    end

    // Keypad: a closed key pulls its row low while its column is driven low
    always_comb begin
        row_n = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!col_n[c] && keys[c*ROWS+r]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_tick && k < 300);
        if (!frame_tick) check("tick_timeout", 32'(frame_tick), 32'd1);
    endtask

    task automatic check_events(input string tag, input logic [4:0] exp [$]);
        check({tag, "_count"}, 32'(evq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < evq.size()) check(tag, 32'(evq[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        // Reset state
        cycles(3);
        check("rst_col_n", 32'(col_n), 32'hF);
        check("rst_key_map", 32'(key_map), 32'h0);
        check("rst_frame_tick", 32'(frame_tick), 32'h0);
        check("rst_evt_valid", 32'(evt_valid), 32'h0);
        check("rst_evt_code", 32'(evt_code), 32'h0);
        check("rst_evt_press", 32'(evt_press), 32'h0);

        // Key 9 (col 2, row 1) held from frame 0
        keys[9] = 1'b1;
        rst_n = 1'b1;
        cycles(1);
        check("col0_after_rst", 32'(col_n), 32'hE);
        wait_tick();
        t1 = cyc;
        check("km_tick1", 32'(key_map), 32'h0);
        wait_tick();
        check("frame_period", 32'(cyc - t1), 32'd80);
        check("km_tick2", 32'(key_map), 32'h0);
        wait_tick();
        check("km_tick3", 32'(key_map), 32'h0200);
        check("valid_at_tick", 32'(evt_valid), 32'h0);
        cycles(1);
        check("valid_plus1", 32'(evt_valid), 32'h0);
        cycles(1);
        check("valid_plus2", 32'(evt_valid), 32'h1);
        check("code_plus2", 32'(evt_code), 32'd9);
        check("press_plus2", 32'(evt_press), 32'h1);
        cycles(4);
        check_events("press9", '{5'h13});
        evq.delete();

        // Release key 9
        wait_tick();
        keys = '0;
        wait_tick();
        wait_tick();
        check("km_rel2", 32'(key_map), 32'h0200);
        wait_tick();
        check("km_rel3", 32'(key_map), 32'h0);
        cycles(5);
        check_events("release9", '{5'h12});
        evq.delete();

        // Bounce on alternate frames
        wait_tick();
        for (int f = 0; f < 6; f++) begin
            keys[9] = (f % 2 == 0);
            wait_tick();
            check("bounce_km", 32'(key_map), 32'h0);
        end
        check("bounce_no_evts", 32'(evq.size()), 32'd0);
        keys[9] = 1'b1;
        wait_tick();
        wait_tick();
        check("settle_km2", 32'(key_map), 32'h0);
        wait_tick();
        check("settle_km3", 32'(key_map), 32'h0200);
        cycles(5);
        check_events("bounce_press", '{5'h13});
        keys = '0;
        wait_tick();
        wait_tick();
        wait_tick();
        cycles(5);
        evq.delete();

        // Five presses in one frame with the consumer stalled
        evt_ready = 1'b0;
        wait_tick();
        keys = 16'h8429;
        wait_tick();
        wait_tick();
        wait_tick();
        check("multi_km", 32'(key_map), 32'h8429);
        cycles(10);
        check("stall_valid", 32'(evt_valid), 32'h1);
        check("stall_code", 32'(evt_code), 32'd0);
        check("stall_press", 32'(evt_press), 32'h1);
        cycles(5);
        check("stall_code_hold", 32'(evt_code), 32'd0);
        check("stall_no_pops", 32'(evq.size()), 32'd0);
        evt_ready = 1'b1;
        cycles(12);
        check_events("fifo_order", '{5'h01, 5'h07, 5'h0B, 5'h15, 5'h1F});
        check("drained_valid", 32'(evt_valid), 32'h0);
        evq.delete();
        wait_tick();
        keys = '0;
        wait_tick();
        wait_tick();
        wait_tick();
        cycles(10);
        check("multi_release_km", 32'(key_map), 32'h0);
        evq.delete();

        // Ghost square: codes 0, 1, 4 pressed, code 5 reads closed
        wait_tick();
        keys = 16'h0033;
        wait_tick();
        wait_tick();
        wait_tick();
        wait_tick();
        cycles(8);
`ifdef KEYPAD_GHOST_REJECT_EN
        check("ghost_km", 32'(key_map), 32'h0);
        check("ghost_no_evts", 32'(evq.size()), 32'd0);
`else
        check("ghost_km", 32'(key_map), 32'h0033);
        check_events("ghost_evts", '{5'h01, 5'h03, 5'h09, 5'h0B});
`endif
        wait_tick();
        keys = '0;
        wait_tick();
        wait_tick();
        wait_tick();
        cycles(8);
        evq.delete();

        // Reset in the middle of emission
        evt_ready = 1'b0;
        wait_tick();
        keys = 16'h0084;
        wait_tick();
        wait_tick();
        wait_tick();
        check("pre_rst_km", 32'(key_map), 32'h0084);
        cycles(3);
        check("pre_rst_valid", 32'(evt_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_col_n", 32'(col_n), 32'hF);
        check("mid_rst_key_map", 32'(key_map), 32'h0);
        check("mid_rst_valid", 32'(evt_valid), 32'h0);
        check("mid_rst_code", 32'(evt_code), 32'h0);
        check("mid_rst_press", 32'(evt_press), 32'h0);
        check("mid_rst_tick", 32'(frame_tick), 32'h0);
        evq.delete();
        cycles(2);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        cycles(1);
        check("col0_after_rst2", 32'(col_n), 32'hE);
        wait_tick();
        check("post_rst_km1", 32'(key_map), 32'h0);
        wait_tick();
        wait_tick();
        check("post_rst_km3", 32'(key_map), 32'h0084);
        cycles(6);
        check_events("post_rst_evts", '{5'h05, 5'h0F});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
